// File: rtl/program_loader.sv
// Loads a host word stream into instruction memory from address 0, verifies a
// trailing XOR checksum, and enables the CPU only when the checksum matches.
module program_loader #(
  parameter int WORD_SIZE  = 19,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH:0]   LEN,
  input  logic                  IN_VALID,
  input  logic [WORD_SIZE-1:0]  IN_DATA,
  output logic                  IN_READY,
  output logic                  WR_EN,
  output logic [WORD_SIZE-1:0]  WR_DATA,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic                  CPU_EN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [ADDR_WIDTH:0]   COUNT
);

  // state   | meaning
  // S_IDLE  | waiting for the first START
  // S_LOAD  | accepting program words and writing them
  // S_CHECK | waiting for the checksum word
  // S_RUN   | checksum matched, CPU enabled
  // S_FAIL  | bad length or checksum mismatch
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_FAIL} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH:0]     count_inc;
  logic [WORD_SIZE-1:0]    xor_q, xor_d;
  logic [WORD_SIZE-1:0]    wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_en_q, wr_en_d;
  logic                    done_q, done_d;
  logic                    in_ready_q, cpu_en_q, busy_q, error_q;
  logic                    accept;

  assign accept    = IN_VALID && in_ready_q;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    xor_d     = xor_q;
    wr_data_d = wr_data_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_RUN, S_FAIL: begin
        if (START) begin
          if (LEN == '0 || LEN > MAX_LEN) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_LOAD;
            len_d   = LEN;
            count_d = '0;
            xor_d   = '0;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = IN_DATA;
          addr_d    = count_q[ADDR_WIDTH-1:0];
          count_d   = count_inc;
          xor_d     = xor_q ^ IN_DATA;
          if (count_inc == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // The checksum beat is consumed but never written to memory.
        if (accept) begin
          if (IN_DATA == xor_q) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      xor_q      <= '0;
      wr_data_q  <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      xor_q      <= xor_d;
      wr_data_q  <= wr_data_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      in_ready_q <= (state_d == S_LOAD) || (state_d == S_CHECK);
      cpu_en_q   <= (state_d == S_RUN);
      busy_q     <= (state_d == S_LOAD) || (state_d == S_CHECK);
      error_q    <= (state_d == S_FAIL);
    end
  end

  assign IN_READY = in_ready_q;
  assign WR_EN    = wr_en_q;
  assign WR_DATA  = wr_data_q;
  assign ADDRESS  = addr_q;
  assign CPU_EN   = cpu_en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = error_q;
  assign COUNT    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven loads plus randomized loads, checked
// against a transaction-level model of the expected writes and outcome.
module tb_program_loader;

  logic        CLK = 1'b0;
  logic        RST, START, IN_VALID;
  logic [12:0] LEN;
  logic [18:0] IN_DATA;
  logic        IN_READY, WR_EN, CPU_EN, BUSY, DONE, ERROR;
  logic [18:0] WR_DATA;
  logic [11:0] ADDRESS;
  logic [12:0] COUNT;

  int total = 0;
  int bad   = 0;

  logic [18:0] words [4096];
  bit          pat6 [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  typedef struct {
    int len;
    int pat;      // 0 random words, 1 powers of two, 2 all ones
    bit bad_ck;
    int mode;     // 0 back-to-back, 1 random valid, 2 fixed gap pattern
    bit poke;     // pulse START mid-load
    bit exp_run;
  } vec_t;

  vec_t vecs [6];

  program_loader dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .WR_EN(WR_EN), .WR_DATA(WR_DATA), .ADDRESS(ADDRESS),
    .CPU_EN(CPU_EN), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_wr_en", WR_EN, 0);
    chk("rst_wr_data", WR_DATA, 0);
    chk("rst_address", ADDRESS, 0);
    chk("rst_cpu_en", CPU_EN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_count", COUNT, 0);
  endtask

  task automatic run_load(input int len, input int pat, input bit bad_ck,
                          input int mode, input bit poke, input bit exp_run);
    logic [18:0] x, ck;
    int sent, cyc;
    bit v;
    x = '0;
    for (int i = 0; i < len; i++) begin
      case (pat)
        1:       words[i] = 19'(1 << (i % 19));
        2:       words[i] = 19'h7FFFF;
        default: words[i] = 19'($urandom);
      endcase
      x ^= words[i];
    end
    ck = bad_ck ? (x ^ 19'h7) : x;

    // START together with IN_VALID: that beat must not be taken.
    START = 1'b1; LEN = 13'(len); IN_VALID = 1'b1; IN_DATA = 19'($urandom);
    tick();
    START = 1'b0;
    chk("start_ready", IN_READY, 1);
    chk("start_busy", BUSY, 1);
    chk("start_cpu_en", CPU_EN, 0);
    chk("start_error", ERROR, 0);
    chk("start_wr_en", WR_EN, 0);
    chk("start_count", COUNT, 0);

    sent = 0;
    cyc  = 0;
    while (sent <= len && cyc < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = pat6[cyc % 6];
      endcase
      IN_VALID = v;
      IN_DATA  = !v ? 19'($urandom) : (sent < len ? words[sent] : ck);
      if (poke && cyc == 2) begin
        START = 1'b1; LEN = 13'd2;
      end
      chk("ready_in_load", IN_READY, 1);
      tick();
      START = 1'b0;
      cyc++;
      if (v && sent < len) begin
        chk("wr_en", WR_EN, 1);
        chk("wr_data", WR_DATA, words[sent]);
        chk("address", ADDRESS, sent);
        sent++;
        chk("count", COUNT, sent);
        chk("done_low", DONE, 0);
      end else if (v) begin
        sent++;
        chk("ck_no_write", WR_EN, 0);
        chk("end_done", DONE, exp_run);
        chk("end_cpu_en", CPU_EN, exp_run);
        chk("end_error", ERROR, !exp_run);
        chk("end_ready", IN_READY, 0);
        chk("end_busy", BUSY, 0);
        chk("end_count", COUNT, len);
      end else begin
        chk("gap_wr_en", WR_EN, 0);
        if (sent > 0) begin
          chk("gap_addr_hold", ADDRESS, sent - 1);
          chk("gap_data_hold", WR_DATA, words[sent - 1]);
        end
        chk("gap_count", COUNT, sent);
      end
    end
    chk("load_finished", sent, len + 1);

    IN_VALID = 1'b1; IN_DATA = 19'($urandom);
    tick();
    chk("post_done_pulse", DONE, 0);
    chk("post_cpu_en", CPU_EN, exp_run);
    chk("post_error", ERROR, !exp_run);
    chk("post_ready", IN_READY, 0);
    chk("post_wr_en", WR_EN, 0);
    IN_VALID = 1'b0;
  endtask

  task automatic bad_len(input int len);
    START = 1'b1; LEN = 13'(len); IN_VALID = 1'b1; IN_DATA = 19'($urandom);
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("badlen_error", ERROR, 1);
      chk("badlen_ready", IN_READY, 0);
      chk("badlen_wr_en", WR_EN, 0);
      chk("badlen_busy", BUSY, 0);
      chk("badlen_cpu_en", CPU_EN, 0);
      tick();
    end
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; LEN = '0; IN_VALID = 1'b0; IN_DATA = '0;
    vecs[0] = '{len: 3,    pat: 1, bad_ck: 1'b0, mode: 0, poke: 1'b0, exp_run: 1'b1};
    vecs[1] = '{len: 3,    pat: 1, bad_ck: 1'b1, mode: 0, poke: 1'b0, exp_run: 1'b0};
    vecs[2] = '{len: 1,    pat: 2, bad_ck: 1'b0, mode: 0, poke: 1'b0, exp_run: 1'b1};
    vecs[3] = '{len: 4,    pat: 0, bad_ck: 1'b0, mode: 2, poke: 1'b1, exp_run: 1'b1};
    vecs[4] = '{len: 4096, pat: 0, bad_ck: 1'b0, mode: 0, poke: 1'b0, exp_run: 1'b1};
    vecs[5] = '{len: 7,    pat: 0, bad_ck: 1'b1, mode: 1, poke: 1'b0, exp_run: 1'b0};

    tick();
    tick();
    check_reset_vals();
    RST = 1'b0;
    tick();
    check_reset_vals();

    foreach (vecs[k])
      run_load(vecs[k].len, vecs[k].pat, vecs[k].bad_ck, vecs[k].mode,
               vecs[k].poke, vecs[k].exp_run);

    bad_len(0);
    bad_len(4097);
    run_load(2, 0, 1'b0, 0, 1'b0, 1'b1);

    // Reset in the middle of a load, then restart from address 0.
    START = 1'b1; LEN = 13'd5; IN_VALID = 1'b0;
    tick();
    START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      IN_VALID = 1'b1; IN_DATA = 19'($urandom);
      tick();
    end
    chk("midload_count", COUNT, 2);
    IN_VALID = 1'b0;
    RST = 1'b1;
    tick();
    check_reset_vals();
    RST = 1'b0;
    run_load(2, 0, 1'b0, 0, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      run_load($urandom_range(1, 40), 0, b, 1, 1'b0, !b);
      if (r % 3 == 0) bad_len($urandom_range(4097, 8191));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
